uart_tx_arbiter: RTL

//  Shares the single UART transmit path among NUM_REQ on-chip requesters via valid/ready byte interfaces.

---
 rtl/uart_tx_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter (optional burst lock) sharing one UART TX write port among NUM_REQ valid/ready requesters.
// Accept in IDLE is a same-cycle ready strobe gated by tx_full; write_data is then held high WR_HOLD clk, low WR_HOLD clk.
module uart_tx_arbiter #(
  parameter int DATA_SIZE = 8,
  parameter int NUM_REQ   = 3,
  parameter int MAX_BURST = 1,
  parameter int WR_HOLD   = 10417,
  parameter int GRANT_W   = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*DATA_SIZE-1:0]   req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic                           tx_full,
  output logic                           write_data,
  output logic [DATA_SIZE-1:0]           tx_data,
  output logic [GRANT_W-1:0]             grant_id,
  output logic                           busy
);

  localparam int HOLD_W  = (WR_HOLD > 1) ? $clog2(WR_HOLD) : 1;
  localparam int BURST_W = $clog2(MAX_BURST + 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(WR_HOLD - 1);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);
  localparam logic [GRANT_W-1:0] LAST_REQ  = GRANT_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_SETTLE} state_t;

  state_t               r_state;
  logic [HOLD_W-1:0]    r_hold_cnt;
  logic [BURST_W-1:0]   r_burst_cnt;
  logic [GRANT_W-1:0]   r_rr_ptr;
  logic [GRANT_W-1:0]   r_grant_id;
  logic [DATA_SIZE-1:0] r_tx_data;
  logic                 r_write_data;
  logic                 r_busy;

  logic                 w_owner_vld;
  logic                 w_continue;
  logic                 w_rr_found;
  logic [GRANT_W-1:0]   w_rr_idx;
  logic [GRANT_W-1:0]   w_win;
  logic                 w_accept;
  logic [DATA_SIZE-1:0] w_win_data;

  // A zero burst count means no burst is open, so the first grant after reset goes through round-robin.
  always_comb begin
    w_owner_vld = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (GRANT_W'(i) == r_grant_id) w_owner_vld = req_valid[i];
    end
    w_continue = w_owner_vld && (r_burst_cnt != '0) && (r_burst_cnt < BURST_MAX);

    w_rr_found = 1'b0;
    w_rr_idx   = '0;
    for (int s = 1; s <= NUM_REQ; s++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!w_rr_found && req_valid[i] && ((int'(r_rr_ptr) + s) % NUM_REQ == i)) begin
          w_rr_found = 1'b1;
          w_rr_idx   = GRANT_W'(i);
        end
      end
    end

    w_win    = w_continue ? r_grant_id : w_rr_idx;
    w_accept = (r_state == S_IDLE) && !tx_full && w_rr_found;

    req_ready  = '0;
    w_win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (GRANT_W'(i) == w_win) begin
        req_ready[i] = w_accept;
        w_win_data   = req_data[i*DATA_SIZE +: DATA_SIZE];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_hold_cnt   <= '0;
      r_burst_cnt  <= '0;
      r_rr_ptr     <= LAST_REQ;
      r_grant_id   <= '0;
      r_tx_data    <= '0;
      r_write_data <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_tx_data    <= w_win_data;
            r_write_data <= 1'b1;
            r_grant_id   <= w_win;
            r_hold_cnt   <= HOLD_LAST;
            r_busy       <= 1'b1;
            r_state      <= S_WRITE;
            if (w_continue) begin
              r_burst_cnt <= r_burst_cnt + 1'b1;
            end else begin
              r_burst_cnt <= BURST_W'(1);
              r_rr_ptr    <= w_win;
            end
          end else if (!w_owner_vld) begin
            r_burst_cnt <= '0;
          end
        end
        S_WRITE: begin
          if (r_hold_cnt == '0) begin
            r_write_data <= 1'b0;
            r_hold_cnt   <= HOLD_LAST;
            r_state      <= S_SETTLE;
          end else begin
            r_hold_cnt <= r_hold_cnt - 1'b1;
          end
        end
        S_SETTLE: begin
          if (r_hold_cnt == '0) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_hold_cnt <= r_hold_cnt - 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign write_data = r_write_data;
  assign tx_data    = r_tx_data;
  assign grant_id   = r_grant_id;
  assign busy       = r_busy;

endmodule
